vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_sync_delay.sv | 36 +++
 rtl/vga_timing.sv | 138 +++++++++++++
 tb/tb_vga_timing.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default panel timing, shared types and counter width helper for vga_timing
package vga_timing_pkg;

    localparam int DEF_HDISP   = 800;
    localparam int DEF_HFP     = 40;
    localparam int DEF_HPULSE  = 48;
    localparam int DEF_HBP     = 40;
    localparam int DEF_VDISP   = 480;
    localparam int DEF_VFP     = 13;
    localparam int DEF_VPULSE  = 3;
    localparam int DEF_VBP     = 29;
    localparam bit DEF_HS_POL  = 1'b0;
    localparam bit DEF_VS_POL  = 1'b0;
    localparam int DEF_LATENCY = 2;
    localparam int MAX_LATENCY = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Sync levels carried down the delay chain already at output polarity.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_sync_delay.sv
// rtl/vga_timing_sync_delay.sv - fixed-depth register chain with synchronous reset to a preset value
module sync_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dout = din;
    end else begin : g_chain
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    pipe[i] <= RESET_VAL;
                end
            end else begin
                pipe[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign dout = pipe[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counter with fetch request, line/frame pulses and delayed sync/de
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int HDISP   = DEF_HDISP,
    parameter int HFP     = DEF_HFP,
    parameter int HPULSE  = DEF_HPULSE,
    parameter int HBP     = DEF_HBP,
    parameter int VDISP   = DEF_VDISP,
    parameter int VFP     = DEF_VFP,
    parameter int VPULSE  = DEF_VPULSE,
    parameter int VBP     = DEF_VBP,
    parameter bit HS_POL  = DEF_HS_POL,
    parameter bit VS_POL  = DEF_VS_POL,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                                            pixel_clk,
    input  logic                                            pixel_rst,
    input  logic                                            en,
    output logic [cnt_width(HDISP + HFP + HPULSE + HBP)-1:0] x,
    output logic [cnt_width(VDISP + VFP + VPULSE + VBP)-1:0] y,
    output logic                                            req,
    output logic                                            sof,
    output logic                                            sol,
    output logic                                            hsync,
    output logic                                            vsync,
    output logic                                            de
);

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int XW     = cnt_width(HTOTAL);
    localparam int YW     = cnt_width(VTOTAL);

    // Every boundary is below the total because each back porch is at least one.
    localparam logic [XW-1:0] X_LAST    = XW'(HTOTAL - 1);
    localparam logic [XW-1:0] X_ACT_END = XW'(HDISP);
    localparam logic [XW-1:0] X_HS_BEG  = XW'(HDISP + HFP);
    localparam logic [XW-1:0] X_HS_END  = XW'(HDISP + HFP + HPULSE);
    localparam logic [YW-1:0] Y_LAST    = YW'(VTOTAL - 1);
    localparam logic [YW-1:0] Y_ACT_END = YW'(VDISP);
    localparam logic [YW-1:0] Y_VS_BEG  = YW'(VDISP + VFP);
    localparam logic [YW-1:0] Y_VS_END  = YW'(VDISP + VFP + VPULSE);

    localparam sync_t SYNC_IDLE = sync_t'({~HS_POL, ~VS_POL, 1'b0});

    if (HDISP < 1 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
        VDISP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1 ||
        LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_params
        $error("vga_timing: every timing parameter must be >= 1 and LATENCY must be 0..7");
    end

    run_state_t    state;
    run_state_t    state_nx;
    logic          run_nx;
    logic [XW-1:0] x_nx;
    logic [YW-1:0] y_nx;
    logic          req_nx;
    logic          sol_nx;
    logic          sof_nx;
    sync_t         sync_nx;
    sync_t         sync_now;
    sync_t         sync_out;

    // Leaving idle always lands on (0,0): a stopped raster restarts the frame.
    always_comb begin
        state_nx = state;
        run_nx   = 1'b0;
        x_nx     = '0;
        y_nx     = '0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nx = ST_RUN;
                    run_nx   = 1'b1;
                end
            end
            ST_RUN: begin
                if (en) begin
                    run_nx = 1'b1;
                    if (x == X_LAST) begin
                        x_nx = '0;
                        y_nx = (y == Y_LAST) ? '0 : y + 1'b1;
                    end else begin
                        x_nx = x + 1'b1;
                        y_nx = y;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        req_nx        = run_nx && (x_nx < X_ACT_END) && (y_nx < Y_ACT_END);
        sol_nx        = run_nx && (x_nx == '0);
        sof_nx        = sol_nx && (y_nx == '0);
        sync_nx.hsync = ((x_nx >= X_HS_BEG) && (x_nx < X_HS_END)) ? HS_POL : ~HS_POL;
        sync_nx.vsync = ((y_nx >= Y_VS_BEG) && (y_nx < Y_VS_END)) ? VS_POL : ~VS_POL;
        sync_nx.de    = req_nx;
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state    <= ST_IDLE;
            x        <= '0;
            y        <= '0;
            req      <= 1'b0;
            sol      <= 1'b0;
            sof      <= 1'b0;
            sync_now <= SYNC_IDLE;
        end else begin
            state    <= state_nx;
            x        <= x_nx;
            y        <= y_nx;
            req      <= req_nx;
            sol      <= sol_nx;
            sof      <= sof_nx;
            sync_now <= sync_nx;
        end
    end

    sync_delay #(
        .WIDTH    ($bits(sync_t)),
        .DEPTH    (LATENCY),
        .RESET_VAL(SYNC_IDLE)
    ) u_sync_delay (
        .clk (pixel_clk),
        .rst (pixel_rst),
        .din (sync_now),
        .dout(sync_out)
    );

    assign hsync = sync_out.hsync;
    assign vsync = sync_out.vsync;
    assign de    = sync_out.de;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing at latency 0, latency 3 and inverted sync polarity
module tb_vga_timing;

    localparam int HDISP  = 4;
    localparam int HFP    = 1;
    localparam int HPULSE = 2;
    localparam int HBP    = 1;
    localparam int VDISP  = 3;
    localparam int VFP    = 1;
    localparam int VPULSE = 1;
    localparam int VBP    = 1;
    localparam int HT     = HDISP + HFP + HPULSE + HBP;
    localparam int VT     = VDISP + VFP + VPULSE + VBP;
    localparam int LAT    = 3;

    typedef struct {
        int x;
        int y;
        bit req;
        bit sol;
        bit sof;
        bit hs;
        bit vs;
        bit de;
        bit hs3;
        bit vs3;
        bit de3;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] x0, y0, x3, y3, xp, yp;
    logic req0, sof0, sol0, hs0, vs0, de0;
    logic req3, sof3, sol3, hs3, vs3, de3;
    logic reqp, sofp, solp, hsp, vsp, dep;

    vga_timing #(.HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
                 .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
                 .HS_POL(1'b0), .VS_POL(1'b0), .LATENCY(0)) u_dut0 (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .x(x0), .y(y0), .req(req0),
        .sof(sof0), .sol(sol0), .hsync(hs0), .vsync(vs0), .de(de0));

    vga_timing #(.HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
                 .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
                 .HS_POL(1'b0), .VS_POL(1'b0), .LATENCY(LAT)) u_dut3 (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .x(x3), .y(y3), .req(req3),
        .sof(sof3), .sol(sol3), .hsync(hs3), .vsync(vs3), .de(de3));

    vga_timing #(.HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
                 .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
                 .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(0)) u_dutp (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .x(xp), .y(yp), .req(reqp),
        .sof(sofp), .sol(solp), .hsync(hsp), .vsync(vsp), .de(dep));

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    // Reference: frame time since the last restart, folded into a position.
    bit       m_run = 1'b0;
    int       m_t   = 0;
    bit [2:0] m_hist [LAT+1];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic exp_t model_edge(input bit r, input bit e);
        exp_t ex;
        if (r || !e) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
        end else begin
            m_t++;
        end
        ex.x   = m_run ? (m_t % HT) : 0;
        ex.y   = m_run ? ((m_t / HT) % VT) : 0;
        ex.req = m_run && ex.x < HDISP && ex.y < VDISP;
        ex.sol = m_run && ex.x == 0;
        ex.sof = ex.sol && ex.y == 0;
        ex.hs  = ex.x >= HDISP + HFP && ex.x < HDISP + HFP + HPULSE;
        ex.vs  = ex.y >= VDISP + VFP && ex.y < VDISP + VFP + VPULSE;
        ex.de  = ex.req;
        for (int i = LAT; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = {ex.hs, ex.vs, ex.de};
        if (r) begin
            for (int i = 0; i <= LAT; i++) m_hist[i] = 3'b000;
        end
        {ex.hs3, ex.vs3, ex.de3} = m_hist[LAT];
        return ex;
    endfunction

    task automatic step(input bit r, input bit e);
        exp_t ex;
        rst = r;
        en  = e;
        ex  = model_edge(r, e);
        @(posedge clk);
        sb.push_back(ex);
        n_push++;
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_pop++;
            check("x0",   32'(x0),   32'(e.x));
            check("y0",   32'(y0),   32'(e.y));
            check("req0", 32'(req0), 32'(e.req));
            check("sol0", 32'(sol0), 32'(e.sol));
            check("sof0", 32'(sof0), 32'(e.sof));
            check("hs0",  32'(hs0),  32'(!e.hs));
            check("vs0",  32'(vs0),  32'(!e.vs));
            check("de0",  32'(de0),  32'(e.de));
            check("x3",   32'(x3),   32'(e.x));
            check("y3",   32'(y3),   32'(e.y));
            check("req3", 32'(req3), 32'(e.req));
            check("sol3", 32'(sol3), 32'(e.sol));
            check("sof3", 32'(sof3), 32'(e.sof));
            check("hs3",  32'(hs3),  32'(!e.hs3));
            check("vs3",  32'(vs3),  32'(!e.vs3));
            check("de3",  32'(de3),  32'(e.de3));
            check("xp",   32'(xp),   32'(e.x));
            check("yp",   32'(yp),   32'(e.y));
            check("reqp", 32'(reqp), 32'(e.req));
            check("solp", 32'(solp), 32'(e.sol));
            check("sofp", 32'(sofp), 32'(e.sof));
            check("hsp",  32'(hsp),  32'(e.hs));
            check("vsp",  32'(vsp),  32'(e.vs));
            check("dep",  32'(dep),  32'(e.de));
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (100) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (21) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        repeat (60) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        repeat (60) step(1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0);
        end
        repeat (2) @(negedge clk);
        check("drain", 32'(n_pop), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
